// File: rtl/cr_cceip_64_sa_rdbk.sv
// Readback stage for the statistics counter array: 32-bit register reads with an
// atomic low/high shadow latch, plus a valid/ready dump stream of all snapshot values.
module cr_cceip_64_sa_rdbk #(
    parameter int unsigned N_CNT  = 64,
    parameter int unsigned CNT_W  = 50,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  sa_snapshot [0:N_CNT-1],
    input  logic [CNT_W-1:0]  sa_count    [0:N_CNT-1],
    input  logic              sa_snap,
    input  logic              rd_req,
    input  logic [7:0]        rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_hi_stale,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [63:0]       dump_data,
    output logic              dump_last,
    output logic              dump_busy,
    output logic              dump_err
);

    localparam int unsigned IDX_W = $clog2(N_CNT);
    localparam int unsigned HI_W  = CNT_W - DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CNT - 1);

    typedef enum logic {IDLE, SEND} state_t;

    // Register read path
    logic              rd_ack_q, rd_ack_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_hi_stale_q, rd_hi_stale_d;
    logic              shadow_vld_q, shadow_vld_d;
    logic [HI_W-1:0]   shadow_hi_q, shadow_hi_d;
    logic [IDX_W:0]    shadow_tag_q, shadow_tag_d;

    logic              rd_src;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_word;
    logic [CNT_W-1:0]  rd_val;

    always_comb begin
        rd_src  = rd_addr[7];
        rd_idx  = rd_addr[IDX_W:1];
        rd_word = rd_addr[0];
        rd_val  = rd_src ? sa_count[rd_idx] : sa_snapshot[rd_idx];

        rd_ack_d      = rd_req;
        rd_data_d     = rd_data_q;
        rd_hi_stale_d = rd_hi_stale_q;
        shadow_vld_d  = shadow_vld_q;
        shadow_hi_d   = shadow_hi_q;
        shadow_tag_d  = shadow_tag_q;

        if (rd_req) begin
            if (!rd_word) begin
                rd_data_d     = rd_val[DATA_W-1:0];
                rd_hi_stale_d = 1'b0;
                shadow_hi_d   = rd_val[CNT_W-1:DATA_W];
                shadow_tag_d  = {rd_src, rd_idx};
                shadow_vld_d  = 1'b1;
            end else if (shadow_vld_q && (shadow_tag_q == {rd_src, rd_idx})) begin
                rd_data_d     = DATA_W'(shadow_hi_q);
                rd_hi_stale_d = 1'b0;
                shadow_vld_d  = 1'b0;
            end else begin
                // No matching low-word read: fall back to the current high bits.
                rd_data_d     = DATA_W'(rd_val[CNT_W-1:DATA_W]);
                rd_hi_stale_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ack_q      <= 1'b0;
            rd_data_q     <= '0;
            rd_hi_stale_q <= 1'b0;
            shadow_vld_q  <= 1'b0;
            shadow_hi_q   <= '0;
            shadow_tag_q  <= '0;
        end else begin
            rd_ack_q      <= rd_ack_d;
            rd_data_q     <= rd_data_d;
            rd_hi_stale_q <= rd_hi_stale_d;
            shadow_vld_q  <= shadow_vld_d;
            shadow_hi_q   <= shadow_hi_d;
            shadow_tag_q  <= shadow_tag_d;
        end
    end

    assign rd_ack      = rd_ack_q;
    assign rd_data     = rd_data_q;
    assign rd_hi_stale = rd_hi_stale_q;

    // Dump stream
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [63:0]      dump_data_q, dump_data_d;
    logic             dump_err_q, dump_err_d;
    logic [IDX_W-1:0] idx_next;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dump_data_d = dump_data_q;
        dump_err_d  = dump_err_q;
        idx_next    = idx_q + IDX_W'(1);

        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d     = SEND;
                    idx_d       = '0;
                    dump_data_d = {IDX_W'(0), 8'd0, sa_snapshot[0]};
                    dump_err_d  = 1'b0;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        // Load the next entry on the accepting edge for back-to-back beats.
                        idx_d       = idx_next;
                        dump_data_d = {idx_next, 8'd0, sa_snapshot[idx_next]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == SEND) && sa_snap) begin
            dump_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dump_data_q <= '0;
            dump_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dump_data_q <= dump_data_d;
            dump_err_q  <= dump_err_d;
        end
    end

    assign dump_valid = (state_q == SEND);
    assign dump_busy  = (state_q == SEND);
    assign dump_data  = dump_data_q;
    assign dump_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign dump_err   = dump_err_q;

endmodule

// File: tb/tb_cr_cceip_64_sa_rdbk.sv
// Directed self-checking bench for cr_cceip_64_sa_rdbk: reset, shadowed register
// reads, tag mismatch, pipelined reads, dump with backpressure, dump error and reset.
module tb_cr_cceip_64_sa_rdbk;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [49:0] sa_snapshot [0:63];
    logic [49:0] sa_count    [0:63];
    logic        sa_snap;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        rd_hi_stale;
    logic        dump_start;
    logic        dump_valid;
    logic        dump_ready;
    logic [63:0] dump_data;
    logic        dump_last;
    logic        dump_busy;
    logic        dump_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cr_cceip_64_sa_rdbk #(
        .N_CNT (64),
        .CNT_W (50),
        .DATA_W(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sa_snapshot(sa_snapshot),
        .sa_count   (sa_count),
        .sa_snap    (sa_snap),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .rd_hi_stale(rd_hi_stale),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .dump_busy  (dump_busy),
        .dump_err   (dump_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_one(input logic [7:0] addr);
        rd_req  = 1'b1;
        rd_addr = addr;
        tick();
        rd_req  = 1'b0;
    endtask

    logic [7:0]  b2b_addr [0:3];
    logic [31:0] b2b_data [0:3];
    logic [63:0] hold_data;
    logic        holding;
    int          beat;
    int          cyc;

    initial begin
        rst_n      = 1'b0;
        sa_snap    = 1'b0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            sa_snapshot[i] = {$urandom, $urandom};
            sa_count[i]    = {$urandom, $urandom};
        end

        // 1. reset with random activity on the inputs
        repeat (3) begin
            rd_req     = 1'($urandom);
            rd_addr    = 8'($urandom);
            dump_start = 1'($urandom);
            dump_ready = 1'($urandom);
            sa_snap    = 1'($urandom);
            tick();
        end
        chk("rst_rd_ack", 64'(rd_ack), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_dump_valid", 64'(dump_valid), 64'd0);
        chk("rst_dump_busy", 64'(dump_busy), 64'd0);
        chk("rst_dump_err", 64'(dump_err), 64'd0);
        rd_req = 1'b0; dump_start = 1'b0; dump_ready = 1'b0; sa_snap = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // 2. atomic low/high split through the shadow
        sa_snapshot[5] = 50'h3_FFFF_1234_5678;
        rd_one(8'h0A);
        chk("split_lo_ack", 64'(rd_ack), 64'd1);
        chk("split_lo_data", 64'(rd_data), 64'h1234_5678);
        sa_snapshot[5] = '0;
        rd_one(8'h0B);
        chk("split_hi_data", 64'(rd_data), 64'h0003_FFFF);
        chk("split_hi_stale", 64'(rd_hi_stale), 64'd0);
        rd_one(8'h0B);
        chk("split_hi2_data", 64'(rd_data), 64'd0);
        chk("split_hi2_stale", 64'(rd_hi_stale), 64'd1);
        tick();
        chk("rd_ack_idle", 64'(rd_ack), 64'd0);
        chk("rd_data_hold", 64'(rd_data), 64'd0);

        // 3. tag mismatch between live and snapshot source
        sa_count[2]    = 50'h1_AAAA_0000_1111;
        sa_snapshot[2] = 50'h2_5555_DEAD_BEEF;
        rd_one(8'h84);
        chk("tag_lo_data", 64'(rd_data), 64'h0000_1111);
        rd_one(8'h05);
        chk("tag_hi_data", 64'(rd_data), 64'h0002_5555);
        chk("tag_hi_stale", 64'(rd_hi_stale), 64'd1);

        // 4. back-to-back pipelined reads
        sa_snapshot[0] = 50'h0_1234_CAFE_F00D;
        sa_count[1]    = 50'h3_0001_8765_4321;
        b2b_addr[0] = 8'h00; b2b_data[0] = 32'hCAFE_F00D;
        b2b_addr[1] = 8'h01; b2b_data[1] = 32'h0000_1234;
        b2b_addr[2] = 8'h82; b2b_data[2] = 32'h8765_4321;
        b2b_addr[3] = 8'h83; b2b_data[3] = 32'h0003_0001;
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = b2b_addr[i];
            tick();
            chk($sformatf("b2b_ack%0d", i), 64'(rd_ack), 64'd1);
            chk($sformatf("b2b_data%0d", i), 64'(rd_data), 64'(b2b_data[i]));
            if (i == 1 || i == 3)
                chk($sformatf("b2b_stale%0d", i), 64'(rd_hi_stale), 64'd0);
        end
        rd_req = 1'b0;
        tick();
        chk("b2b_ack_end", 64'(rd_ack), 64'd0);

        // 5. dump with alternating backpressure
        for (int i = 0; i < 64; i++) sa_snapshot[i] = 50'(i + 1);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        beat = 0; cyc = 0; holding = 1'b0; hold_data = '0;
        while (beat < 64 && cyc < 1000) begin
            dump_ready = cyc[0];
            chk("d5_valid", 64'(dump_valid), 64'd1);
            if (holding) chk("d5_stable", dump_data, hold_data);
            if (dump_valid && dump_ready) begin
                chk($sformatf("d5_data%0d", beat), dump_data, {6'(beat), 8'd0, 50'(beat + 1)});
                chk($sformatf("d5_last%0d", beat), 64'(dump_last), 64'(beat == 63));
                beat++;
            end
            holding   = dump_valid && !dump_ready;
            hold_data = dump_data;
            tick();
            cyc++;
        end
        dump_ready = 1'b0;
        chk("d5_beats", 64'(beat), 64'd64);
        chk("d5_busy_end", 64'(dump_busy), 64'd0);
        chk("d5_valid_end", 64'(dump_valid), 64'd0);
        chk("d5_err", 64'(dump_err), 64'd0);

        // 6a. sa_snap during a dump sets a sticky error
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        beat = 0; cyc = 0;
        while (dump_busy && cyc < 200) begin
            sa_snap = (cyc == 3);
            if (dump_valid) beat++;
            tick();
            cyc++;
            if (cyc > 4 && dump_busy) chk("d6_err_set", 64'(dump_err), 64'd1);
        end
        sa_snap = 1'b0;
        chk("d6_beats", 64'(beat), 64'd64);
        tick();
        tick();
        chk("d6_err_sticky", 64'(dump_err), 64'd1);

        // 6b. next start clears the error; reset at beat 10 abandons the dump
        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("d6_err_clr", 64'(dump_err), 64'd0);
        dump_ready = 1'b1;
        cyc = 0;
        while (dump_data[63:58] != 6'd10 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("d6_b10_data", dump_data, {6'd10, 8'd0, 50'd11});
        rst_n = 1'b0;
        tick();
        chk("d6_rst_valid", 64'(dump_valid), 64'd0);
        chk("d6_rst_busy", 64'(dump_busy), 64'd0);
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            chk("d6_no_beat", 64'(dump_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
